pkt_hdlc_framer: RTL and testbench
==================================

PKT_HDLC_FRAMER -- requirements
Module: pkt_hdlc_framer

Interface
REQ-001 Parameter FLAG, 8'h7E: frame delimiter byte.
REQ-002 Parameter ESC, 8'h7D: escape prefix byte.
REQ-003 Parameter XMASK, 8'h20: XOR mask applied to an escaped byte.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rd_data  input  8  head byte of the upstream packet FIFO; first-word-fall-through, valid while empty=0.
REQ-007 rd_last  input  1  head byte is the last byte of its packet; valid while empty=0.
REQ-008 empty  input  1  upstream FIFO holds no byte.
REQ-009 rd_ena  output  1  pop strobe to the FIFO; only asserted when empty=0.
REQ-010 out_data  output  8  framed byte stream.
REQ-011 out_valid  output  1  out_data holds a byte.
REQ-012 out_ready  input  1  sink accepts out_data this cycle when out_valid=1.

Function
REQ-013 Each packet SHALL be sent as: FLAG, stuffed payload, stuffed checksum, FLAG.
REQ-014 Stuffing SHALL replace any byte equal to FLAG or ESC with two bytes: ESC, then (byte ^ XMASK). All other bytes pass unchanged.
REQ-015 The checksum SHALL be (0 - sum of raw payload bytes) mod 256, so that the raw payload plus checksum sums to 0 mod 256. It is stuffed like payload.
REQ-016 The output SHALL use one register stage (out_data/out_valid). It loads when out_valid=0 or out_ready=1 ("slot free").
REQ-017 out_data SHALL remain stable, and out_valid SHALL stay high, until the sink accepts the byte.
REQ-018 The FSM SHALL have these states: IDLE, SOF, DATA, ESC2, CSUM, CSUM2, EOF.
REQ-019 IDLE: when empty=0, go to SOF and clear the checksum accumulator. No pop.
REQ-020 SOF: when the slot is free, load FLAG and go to DATA.
REQ-021 DATA, when the slot is free and empty=0: assert rd_ena for exactly one cycle and add rd_data to the accumulator.
- Byte needs escape: load ESC, latch rd_data^XMASK, go to ESC2.
- Otherwise: load rd_data.
- rd_last=1 and no escape: go to CSUM.
REQ-022 ESC2: when the slot is free, load the latched byte. Next state is CSUM if the popped byte had rd_last=1, else DATA.
REQ-023 CSUM: when the slot is free, load the checksum, or ESC if stuffing is needed. Go to CSUM2 (escaped) or EOF.
REQ-024 CSUM2: when the slot is free, load checksum^XMASK and go to EOF.
REQ-025 EOF: when the slot is free, load FLAG and go to IDLE.
REQ-026 If no byte is loaded and out_ready=1, out_valid SHALL drop to 0 on the next edge.
REQ-027 An empty FIFO mid-packet (DATA with empty=1) SHALL stall: no pop, no load, gaps on the output allowed. The partial checksum is held.
REQ-028 rd_ena SHALL never assert outside DATA, nor while empty=1, nor while the slot is not free.
REQ-029 The accumulator SHALL be 8-bit and wrap mod 256.
REQ-030 Latency: when empty falls in IDLE, FLAG SHALL appear on out_valid 2 cycles later. Sustained throughput with out_ready=1 SHALL be 1 output byte per cycle.
REQ-031 A packet with a single byte and rd_last=1 SHALL produce the frame FLAG, byte, checksum, FLAG.
REQ-032 Back-to-back packets SHALL each get their own leading and trailing FLAG; flags are not shared.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state IDLE, out_valid=0, out_data=8'h00, rd_ena=0, accumulator 0, latch 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately. The FIFO is not popped further. After release, the block restarts at IDLE and the next frame begins with FLAG.

Verification
REQ-035 Packet {01,02,03} with rd_last on 03 and out_ready=1 -> 7E 01 02 03 FA 7E, with 3 rd_ena pulses.
REQ-036 Packet {7E,7D} -> 7E 7D 5E 7D 5D 05 7E.
REQ-037 Packet {83} (checksum 7D) -> 7E 83 7D 5D 7E.
REQ-038 out_ready toggled randomly while streaming 64 random packets -> decoded frames match the payloads; out_data is stable while out_valid=1 and out_ready=0; rd_ena count equals the byte count.
REQ-039 FIFO goes empty after byte 2 of 4 for 10 cycles -> no rd_ena during the gap; the output resumes with a correct checksum.
REQ-040 rst_n pulsed low during the DATA of a packet -> out_valid=0 at once; the next packet produces a clean frame starting 7E.

Source files
------------

// File: rtl/pkt_hdlc_framer.sv
// HDLC-style framer: pulls packets from a first-word-fall-through FIFO and emits
// FLAG, byte-stuffed payload, stuffed two's-complement checksum, FLAG.
module pkt_hdlc_framer #(
    parameter logic [7:0] FLAG  = 8'h7E,
    parameter logic [7:0] ESC   = 8'h7D,
    parameter logic [7:0] XMASK = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rd_data,
    input  logic       rd_last,
    input  logic       empty,
    output logic       rd_ena,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOF   = 3'd1,
        S_DATA  = 3'd2,
        S_ESC2  = 3'd3,
        S_CSUM  = 3'd4,
        S_CSUM2 = 3'd5,
        S_EOF   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] latch_q, latch_d;
    logic       last_q, last_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       slot_free_s;
    logic       load_s;
    logic       rd_ena_s;
    logic [7:0] csum_s;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == FLAG) || (b == ESC);
    endfunction

    assign slot_free_s = !out_valid_q || out_ready;
    assign csum_s      = 8'h00 - acc_q;
    assign rd_ena      = rd_ena_s;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

    // Next-state, pop strobe and output-slot load decisions.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        latch_d    = latch_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        rd_ena_s   = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_SOF;
                    acc_d   = 8'h00;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SOF: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    out_data_d = FLAG;
                    state_d    = S_DATA;
                end else begin
                    state_d = S_SOF;
                end
            end
            S_DATA: begin
                // A drained FIFO stalls here with the partial sum held.
                if (slot_free_s && !empty) begin
                    rd_ena_s = 1'b1;
                    load_s   = 1'b1;
                    acc_d    = acc_q + rd_data;
                    if (needs_esc(rd_data)) begin
                        out_data_d = ESC;
                        latch_d    = rd_data ^ XMASK;
                        last_d     = rd_last;
                        state_d    = S_ESC2;
                    end else begin
                        out_data_d = rd_data;
                        state_d    = rd_last ? S_CSUM : S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_ESC2: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    out_data_d = latch_q;
                    state_d    = last_q ? S_CSUM : S_DATA;
                end else begin
                    state_d = S_ESC2;
                end
            end
            S_CSUM: begin
                if (slot_free_s) begin
                    load_s = 1'b1;
                    if (needs_esc(csum_s)) begin
                        out_data_d = ESC;
                        state_d    = S_CSUM2;
                    end else begin
                        out_data_d = csum_s;
                        state_d    = S_EOF;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM2: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    out_data_d = csum_s ^ XMASK;
                    state_d    = S_EOF;
                end else begin
                    state_d = S_CSUM2;
                end
            end
            S_EOF: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    out_data_d = FLAG;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_EOF;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, accumulator, escape latch and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 8'h00;
            latch_q     <= 8'h00;
            last_q      <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            latch_q     <= latch_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pkt_hdlc_framer.sv
// Scoreboard bench for pkt_hdlc_framer: a FIFO model feeds packets, a reference
// encoder queues the expected byte stream, and a monitor checks every accepted byte.
module tb_pkt_hdlc_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       rd_last = 1'b0;
    logic       empty = 1'b1;
    logic       rd_ena;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;

    pkt_hdlc_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .empty     (empty),
        .rd_ena    (rd_ena),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    logic [8:0] fifo_q[$];
    logic [8:0] pend_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pushed_bytes = 0;
    int         pop_cnt = 0;
    logic       rand_ready = 1'b0;
    logic       pop_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic stuff(input logic [7:0] b);
        if (b == 8'h7E || b == 8'h7D) begin
            exp_q.push_back(8'h7D);
            exp_q.push_back(b ^ 8'h20);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    // Reference encoding of pkt_q; only the first n_now bytes enter the FIFO now.
    task automatic push_pkt(input int n_now);
        int sum;
        sum = 0;
        exp_q.push_back(8'h7E);
        for (int i = 0; i < pkt_q.size(); i++) begin
            logic [8:0] ent;
            sum = sum + int'(pkt_q[i]);
            stuff(pkt_q[i]);
            ent = {(i == pkt_q.size() - 1) ? 1'b1 : 1'b0, pkt_q[i]};
            if (i < n_now) begin
                fifo_q.push_back(ent);
                pushed_bytes++;
            end else begin
                pend_q.push_back(ent);
            end
        end
        stuff(8'((256 - (sum % 256)) % 256));
        exp_q.push_back(8'h7E);
    endtask

    task automatic release_pend();
        while (pend_q.size() != 0) begin
            fifo_q.push_back(pend_q.pop_front());
            pushed_bytes++;
        end
    endtask

    task automatic drain(input int bound);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // FIFO model and sink readiness: pop after the edge, present the new head.
    initial begin
        logic [31:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
            end
            pop_pend = 1'b0;
            r = $urandom;
            if (fifo_q.size() != 0) begin
                rd_data = fifo_q[0][7:0];
                rd_last = fifo_q[0][8];
                empty   = 1'b0;
            end else begin
                rd_data = r[7:0];
                rd_last = r[8];
                empty   = 1'b1;
            end
            out_ready = rand_ready ? r[9] : 1'b1;
            @(negedge clk);
            pop_pend = rd_ena;
        end
    end

    // Monitor: accepted bytes against the scoreboard, hold stability, pop legality.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (rd_ena) begin
                    pop_cnt++;
                    chk("rd_ena_when_empty", 32'(empty), 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 32'(out_data), 32'h1FF);
                    end else begin
                        chk("frame_byte", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        int p0;
        int n;
        int gap_pops;
        logic [31:0] r;

        #23;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'h00);
        chk("reset_rd_ena", 32'(rd_ena), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // {01,02,03}: latency, back-to-back throughput and pop count.
        p0 = pop_cnt;
        pkt_q = '{8'h01, 8'h02, 8'h03};
        push_pkt(3);
        n = 0;
        while (empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("empty_seen", 32'(empty), 32'd0);
        @(negedge clk);
        chk("latency_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_c2_valid", 32'(out_valid), 32'd1);
        chk("latency_c2_flag", 32'(out_data), 32'h7E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("throughput_valid", 32'(out_valid), 32'd1);
        end
        drain(100);
        chk("pkt123_pops", 32'(pop_cnt - p0), 32'd3);

        pkt_q = '{8'h7E, 8'h7D};
        push_pkt(2);
        drain(100);
        pkt_q = '{8'h83};
        push_pkt(1);
        drain(100);

        // FIFO runs dry after two of four bytes for ten cycles.
        pkt_q = '{8'h11, 8'h7E, 8'h33, 8'h44};
        push_pkt(2);
        n = 0;
        while (fifo_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        gap_pops = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_ena) gap_pops++;
        end
        chk("gap_no_pop", 32'(gap_pops), 32'd0);
        release_pend();
        drain(100);

        // 64 random packets with a randomly stalling sink.
        rand_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            pkt_q.delete();
            r = $urandom;
            n = int'(r[2:0]) + 1;
            for (int j = 0; j < n; j++) begin
                r = $urandom;
                if (r[9:8] == 2'b00) begin
                    pkt_q.push_back(r[10] ? 8'h7E : 8'h7D);
                end else begin
                    pkt_q.push_back(r[7:0]);
                end
            end
            push_pkt(n);
        end
        drain(20000);
        rand_ready = 1'b0;

        // Reset in the middle of DATA abandons the frame.
        p0 = pop_cnt;
        pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_pkt(8);
        n = 0;
        while (pop_cnt < p0 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_frame_reached", 32'(pop_cnt - p0 >= 3), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_rd_ena", 32'(rd_ena), 32'd0);
        pushed_bytes = pushed_bytes - fifo_q.size();
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pkt_q = '{8'h7E, 8'h55};
        push_pkt(2);
        drain(100);

        chk("total_pops", 32'(pop_cnt), 32'(pushed_bytes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
